// File: rtl/modinv_helper_init_multi_pkg.sv
// Shared types and helpers for the modular-invertor init sequencer.
// Holds mode encodings, clog2 and the memory-latency legality check.
package modinv_helper_init_multi_pkg;

  typedef enum logic [1:0] {
    MODE_STD   = 2'b00,
    MODE_SWAP  = 2'b01,
    MODE_SCRUB = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_t;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit lat_ok(input int l);
    return (l >= MEM_LAT_MIN) && (l <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/modinv_helper_init_multi_if.sv
// Handshake, operand-read and buffer-write bundle of the init sequencer.
// master: sequencer side (drives rdy/done/addresses/writes); slave: environment.
interface modinv_helper_init_multi_if #(
  parameter int WORD_WIDTH        = 32,
  parameter int OPERAND_ADDR_BITS = 3,
  parameter int BUFFER_ADDR_BITS  = 4
);
  import modinv_helper_init_multi_pkg::*;

  logic                         ena;
  mode_t                        mode;
  logic                         rdy;
  logic                         done;
  logic                         op_zero;
  logic [OPERAND_ADDR_BITS-1:0] a_addr;
  logic [OPERAND_ADDR_BITS-1:0] q_addr;
  logic [WORD_WIDTH-1:0]        a_din;
  logic [WORD_WIDTH-1:0]        q_din;
  logic [BUFFER_ADDR_BITS-1:0]  r_addr;
  logic [BUFFER_ADDR_BITS-1:0]  s_addr;
  logic [BUFFER_ADDR_BITS-1:0]  u_addr;
  logic [BUFFER_ADDR_BITS-1:0]  v_addr;
  logic                         r_wren;
  logic                         s_wren;
  logic                         u_wren;
  logic                         v_wren;
  logic [WORD_WIDTH-1:0]        r_dout;
  logic [WORD_WIDTH-1:0]        s_dout;
  logic [WORD_WIDTH-1:0]        u_dout;
  logic [WORD_WIDTH-1:0]        v_dout;

  modport master (
    input  ena, mode, a_din, q_din,
    output rdy, done, op_zero, a_addr, q_addr,
    output r_addr, s_addr, u_addr, v_addr,
    output r_wren, s_wren, u_wren, v_wren,
    output r_dout, s_dout, u_dout, v_dout
  );

  modport slave (
    output ena, mode, a_din, q_din,
    input  rdy, done, op_zero, a_addr, q_addr,
    input  r_addr, s_addr, u_addr, v_addr,
    input  r_wren, s_wren, u_wren, v_wren,
    input  r_dout, s_dout, u_dout, v_dout
  );

endinterface

// File: rtl/modinv_helper_delay_line.sv
// Fixed-depth shift register with asynchronous active-high reset.
// Ports: clk, rst, d_i (input word), q_o (d_i delayed by DEPTH cycles).
module modinv_helper_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/modinv_helper_init_multi.sv
// Init sequencer: streams A/Q words and fills R/S/U/V buffers in one pass.
// Ports: clk, rst (async high), bus (master: handshake, reads, writes).
module modinv_helper_init_multi
  import modinv_helper_init_multi_pkg::*;
#(
  parameter int WORD_WIDTH        = 32,
  parameter int OPERAND_NUM_WORDS = 8,
  parameter int OPERAND_ADDR_BITS = 3,
  parameter int BUFFER_NUM_WORDS  = 9,
  parameter int BUFFER_ADDR_BITS  = 4,
  parameter int MEM_LATENCY       = 1
) (
  input logic                        clk,
  input logic                        rst,
  modinv_helper_init_multi_if.master bus
);

  if (!lat_ok(MEM_LATENCY)) begin : g_bad_lat
    $error("MEM_LATENCY must be within 1..3");
  end
  if (BUFFER_NUM_WORDS < OPERAND_NUM_WORDS) begin : g_bad_buf
    $error("BUFFER_NUM_WORDS must be >= OPERAND_NUM_WORDS");
  end

  localparam int LAST = BUFFER_NUM_WORDS + MEM_LATENCY;
  localparam int CW   = clog2(LAST + 1);
  localparam int OAB  = OPERAND_ADDR_BITS;
  localparam int BAB  = BUFFER_ADDR_BITS;
  localparam int DLW  = BAB + 2;

  localparam logic [CW-1:0] LAST_C = CW'(LAST);
  localparam logic [CW-1:0] OPN_C  = CW'(OPERAND_NUM_WORDS);
  localparam logic [CW-1:0] BUF_C  = CW'(BUFFER_NUM_WORDS);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  localparam logic [WORD_WIDTH-1:0] W_ONE = WORD_WIDTH'(1);

  logic [CW-1:0] cnt_q;
  mode_t         mode_q;
  logic          done_q;
  logic          acc_q;
  logic          acc_d;
  logic          zero_q;

  logic           start;
  logic           rd_act;
  logic           wr_iss;
  logic [BAB-1:0] iss_idx;
  logic [DLW-1:0] str_in;
  logic [DLW-1:0] str_out;
  logic           wr_en;
  logic           wr_op;
  logic [BAB-1:0] wr_idx;

  logic                  scrub;
  logic                  swap;
  logic [WORD_WIDTH-1:0] src_u;
  logic [WORD_WIDTH-1:0] src_v;

  assign start  = bus.ena && (cnt_q == '0);
  assign rd_act = (cnt_q != '0) && (cnt_q <= OPN_C);
  assign wr_iss = (cnt_q != '0) && (cnt_q <= BUF_C);

  assign iss_idx = wr_iss ? BAB'(cnt_q - ONE_C) : '0;

  // Issue-time strobe/index, re-timed to meet the read data.
  assign str_in = {wr_iss, rd_act, iss_idx};

  modinv_helper_delay_line #(
    .WIDTH (DLW),
    .DEPTH (MEM_LATENCY)
  ) u_align (
    .clk (clk),
    .rst (rst),
    .d_i (str_in),
    .q_o (str_out)
  );

  assign {wr_en, wr_op, wr_idx} = str_out;

  assign scrub = (mode_q == MODE_SCRUB);
  assign swap  = (mode_q == MODE_SWAP);
  assign src_u = swap ? bus.a_din : bus.q_din;
  assign src_v = swap ? bus.q_din : bus.a_din;

  // Running OR of the v-source, including the word written this cycle.
  assign acc_d = acc_q | (wr_en & wr_op & (|src_v));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      mode_q <= MODE_STD;
      done_q <= 1'b0;
      acc_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      done_q <= (cnt_q == LAST_C);
      if (start) begin
        cnt_q  <= ONE_C;
        mode_q <= bus.mode;
        acc_q  <= 1'b0;
        zero_q <= 1'b0;
      end else if (cnt_q != '0) begin
        acc_q <= acc_d;
        if (cnt_q == LAST_C) begin
          cnt_q  <= '0;
          zero_q <= ~acc_d & ~scrub;
        end else begin
          cnt_q <= cnt_q + ONE_C;
        end
      end
    end
  end

  assign bus.rdy     = (cnt_q == '0);
  assign bus.done    = done_q;
  assign bus.op_zero = zero_q;

  assign bus.a_addr = rd_act ? OAB'(cnt_q - ONE_C) : '0;
  assign bus.q_addr = bus.a_addr;

  assign bus.r_wren = wr_en;
  assign bus.s_wren = wr_en;
  assign bus.u_wren = wr_en;
  assign bus.v_wren = wr_en;

  assign bus.r_addr = wr_en ? wr_idx : '0;
  assign bus.s_addr = bus.r_addr;
  assign bus.u_addr = bus.r_addr;
  assign bus.v_addr = bus.r_addr;

  assign bus.r_dout = '0;
  assign bus.s_dout = (wr_en && !scrub && wr_idx == '0) ? W_ONE : '0;
  assign bus.u_dout = (wr_en && wr_op && !scrub) ? src_u : '0;
  assign bus.v_dout = (wr_en && wr_op && !scrub) ? src_v : '0;

endmodule

// File: tb/tb_modinv_helper_init_multi.sv
// Bench for the init sequencer: default and latency-3 instances.
// Random and directed operations checked against a word-level model.
module tb_modinv_helper_init_multi;
  import modinv_helper_init_multi_pkg::*;

  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] r;
    logic [31:0] s;
    logic [31:0] u;
    logic [31:0] v;
    bit          eq;
  } wr_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   ncyc;
  int   rd_bad;
  int   base0;
  int   base1;
  wr_t  wlog0[$];
  wr_t  wlog1[$];

  logic [31:0] amem [8];
  logic [31:0] qmem [8];
  logic [31:0] p1a [2];
  logic [31:0] p1q [2];

  modinv_helper_init_multi_if #(
    .WORD_WIDTH(32), .OPERAND_ADDR_BITS(3), .BUFFER_ADDR_BITS(4)
  ) b0 ();
  modinv_helper_init_multi_if #(
    .WORD_WIDTH(32), .OPERAND_ADDR_BITS(2), .BUFFER_ADDR_BITS(2)
  ) b1 ();

  modinv_helper_init_multi #(
    .WORD_WIDTH(32), .OPERAND_NUM_WORDS(8), .OPERAND_ADDR_BITS(3),
    .BUFFER_NUM_WORDS(9), .BUFFER_ADDR_BITS(4), .MEM_LATENCY(1)
  ) u0 (.clk(clk), .rst(rst), .bus(b0));

  modinv_helper_init_multi #(
    .WORD_WIDTH(32), .OPERAND_NUM_WORDS(4), .OPERAND_ADDR_BITS(2),
    .BUFFER_NUM_WORDS(4), .BUFFER_ADDR_BITS(2), .MEM_LATENCY(3)
  ) u1 (.clk(clk), .rst(rst), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    b0.a_din <= amem[b0.a_addr];
    b0.q_din <= qmem[b0.q_addr];
    p1a[0]   <= amem[b1.a_addr];
    p1q[0]   <= qmem[b1.q_addr];
    p1a[1]   <= p1a[0];
    p1q[1]   <= p1q[0];
    b1.a_din <= p1a[1];
    b1.q_din <= p1q[1];
  end

  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (b0.a_addr != b0.q_addr || b1.a_addr != b1.q_addr)
      rd_bad <= rd_bad + 1;
    if (b0.r_wren | b0.s_wren | b0.u_wren | b0.v_wren)
      wlog0.push_back('{ncyc, int'(b0.r_addr),
        b0.r_dout, b0.s_dout, b0.u_dout, b0.v_dout,
        (b0.r_wren & b0.s_wren & b0.u_wren & b0.v_wren) &&
        b0.r_addr == b0.s_addr && b0.r_addr == b0.u_addr &&
        b0.r_addr == b0.v_addr});
    if (b1.r_wren | b1.s_wren | b1.u_wren | b1.v_wren)
      wlog1.push_back('{ncyc, int'(b1.r_addr),
        b1.r_dout, b1.s_dout, b1.u_dout, b1.v_dout,
        (b1.r_wren & b1.s_wren & b1.u_wren & b1.v_wren) &&
        b1.r_addr == b1.s_addr && b1.r_addr == b1.u_addr &&
        b1.r_addr == b1.v_addr});
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected buffer words, straight from the mode table.
  function automatic void exp_words(input int m, input int j,
      input int nop, output logic [31:0] r, output logic [31:0] s,
      output logic [31:0] u, output logic [31:0] v);
    r = 0; s = 0; u = 0; v = 0;
    if (m == 2) return;
    if (j == 0) s = 1;
    if (j < nop) begin
      u = (m == 1) ? amem[j] : qmem[j];
      v = (m == 1) ? qmem[j] : amem[j];
    end
  endfunction

  function automatic logic [31:0] exp_zero(input int m, input int nop);
    if (m == 2) return 0;
    for (int j = 0; j < nop; j++)
      if (((m == 1) ? qmem[j] : amem[j]) != 0) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] done_of(input int d);
    return 32'((d == 0) ? b0.done : b1.done);
  endfunction

  function automatic logic [31:0] rdy_of(input int d);
    return 32'((d == 0) ? b0.rdy : b1.rdy);
  endfunction

  function automatic logic [31:0] opz_of(input int d);
    return 32'((d == 0) ? b0.op_zero : b1.op_zero);
  endfunction

  task automatic set_ena(input int d, input bit e, input int m);
    if (d == 0) begin b0.ena = e; b0.mode = mode_t'(m); end
    else begin b1.ena = e; b1.mode = mode_t'(m); end
  endtask

  // Start pulse; s0 is the start cycle id.
  task automatic start_op(input int d, input int m, output int s0);
    chk("rdy_idle", rdy_of(d), 1);
    s0 = ncyc;
    set_ena(d, 1'b1, m);
    tick();
    set_ena(d, 1'b0, m);
    chk("rdy_busy", rdy_of(d), 0);
    chk("opz_clr", opz_of(d), 0);
  endtask

  // n counts cycles from the start cycle to the done cycle.
  task automatic wait_done(input int d, input int lat_exp);
    int n;
    n = 1;
    for (int k = 0; k < 40 && done_of(d) == 0; k++) begin
      tick();
      n++;
    end
    chk("done_seen", done_of(d), 1);
    chk("latency", n, lat_exp);
    chk("rdy_at_done", rdy_of(d), 1);
  endtask

  task automatic check_op(input int d, input int s0, input int m,
                          input int lat, input int nbuf, input int nop);
    int n;
    wr_t e;
    logic [31:0] xr, xs, xu, xv;
    n = (d == 0) ? wlog0.size() - base0 : wlog1.size() - base1;
    chk("n_writes", n, nbuf);
    for (int j = 0; j < nbuf && j < n; j++) begin
      e = (d == 0) ? wlog0[base0 + j] : wlog1[base1 + j];
      exp_words(m, j, nop, xr, xs, xu, xv);
      chk("wr_cycle", e.cyc - s0, 1 + lat + j);
      chk("wr_addr", e.addr, j);
      chk("wr_equal", 32'(e.eq), 1);
      chk("r_word", e.r, xr);
      chk("s_word", e.s, xs);
      chk("u_word", e.u, xu);
      chk("v_word", e.v, xv);
    end
    chk("op_zero", opz_of(d), exp_zero(m, nop));
    if (d == 0) base0 += n;
    else base1 += n;
  endtask

  task automatic full_op(input int d, input int m);
    int s0;
    start_op(d, m, s0);
    wait_done(d, (d == 0) ? 11 : 8);
    check_op(d, s0, m, (d == 0) ? 1 : 3,
             (d == 0) ? 9 : 4, (d == 0) ? 8 : 4);
    tick();
    chk("done_pulse", done_of(d), 0);
    chk("opz_hold", opz_of(d), exp_zero(m, (d == 0) ? 8 : 4));
  endtask

  initial begin
    int s0;
    int s0b;
    int n;
    int dn;
    checks = 0; failures = 0; ncyc = 0; rd_bad = 0;
    base0 = 0; base1 = 0;
    rst = 1'b1;
    set_ena(0, 1'b0, 0);
    set_ena(1, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      amem[i] = 32'h11 + i;
      qmem[i] = 32'hA1 + i;
    end
    repeat (3) tick();
    chk("rst_rdy", 32'(b0.rdy), 1);
    chk("rst_wren", 32'(b0.r_wren | b0.v_wren), 0);
    rst = 1'b0;
    tick();
    chk("rst_done", 32'(b0.done), 0);
    chk("rst_opz", 32'(b0.op_zero), 0);
    chk("rst_aaddr", 32'(b0.a_addr), 0);
    chk("rst_waddr", 32'(b0.u_addr), 0);
    chk("rst_dout", b0.s_dout | b0.u_dout | b0.v_dout, 0);
    chk("rst_rdy1", 32'(b1.rdy), 1);

    full_op(0, 0);
    full_op(0, 1);

    for (int i = 0; i < 8; i++) amem[i] = 0;
    full_op(0, 0);
    repeat (3) tick();
    chk("opz_idle", 32'(b0.op_zero), 1);
    amem[0] = 1;
    full_op(0, 0);

    for (int i = 0; i < 8; i++) begin
      amem[i] = 32'h11 + i;
      qmem[i] = 32'hA1 + i;
    end
    full_op(1, 0);
    full_op(1, 1);

    for (int i = 0; i < 8; i++) qmem[i] = 0;
    s0 = ncyc;
    set_ena(0, 1'b1, 0);
    tick();
    set_ena(0, 1'b1, 1);
    n = 1;
    for (int k = 0; k < 40 && b0.done == 1'b0; k++) begin
      tick();
      n++;
    end
    chk("b2b_done1", 32'(b0.done), 1);
    chk("b2b_lat1", n, 11);
    check_op(0, s0, 0, 1, 9, 8);
    s0b = ncyc;
    tick();
    chk("b2b_restart", 32'(b0.rdy), 0);
    set_ena(0, 1'b0, 1);
    wait_done(0, 11);
    check_op(0, s0b, 1, 1, 9, 8);
    tick();

    for (int i = 0; i < 8; i++) qmem[i] = 32'hA1 + i;
    full_op(0, 2);
    for (int i = 0; i < 8; i++) amem[i] = 0;
    full_op(0, 2);
    for (int i = 0; i < 8; i++) amem[i] = 32'h11 + i;

    start_op(0, 0, s0);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_wren", 32'(b0.r_wren | b0.u_wren), 0);
    chk("mid_rst_rdy", 32'(b0.rdy), 1);
    chk("mid_rst_addr", 32'(b0.a_addr), 0);
    chk("mid_rst_nwr", wlog0.size() - base0, 3);
    base0 = wlog0.size();
    tick();
    rst = 1'b0;
    dn = 0;
    repeat (15) begin
      tick();
      if (b0.done) dn++;
    end
    chk("mid_rst_nodone", dn, 0);

    for (int it = 0; it < 8; it++) begin
      int m;
      for (int i = 0; i < 8; i++) begin
        amem[i] = $urandom;
        qmem[i] = $urandom;
      end
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < 8; i++) amem[i] = 0;
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < 8; i++) qmem[i] = 0;
      m = int'($urandom_range(0, 3));
      full_op(0, m);
      full_op(1, m);
    end

    chk("rd_addr_equal", rd_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
